nr_divider: RTL

NR_DIVIDER -- requirements
Module: nr_divider

---
 rtl/nr_divider.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/nr_divider.sv
// nr_divider: sequential non-restoring divider, 2N-bit dividend by N-bit
// divisor, N-bit quotient and remainder, signed or unsigned per operation.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's-complement operands/results, sampled with start
//   numerator    2N-bit dividend, sampled with start
//   denominator  N-bit divisor, sampled with start
//   quotient     registered N-bit quotient
//   remainder    registered N-bit remainder (sign follows dividend)
//   busy         high in every state except IDLE
//   done         high in IDLE
//   div_zero     last operation had a zero divisor
//   overflow     last operation's quotient did not fit in N bits
//
// state   | meaning
// IDLE    | waiting for start; results and flags hold
// ITER    | N non-restoring steps, one quotient bit per cycle
// CORRECT | merge last quotient bit, restore a negative remainder
// SIGN    | apply signs / range check (or early result) and write outputs

module nr_divider #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [2*N-1:0] numerator,
  input  logic [N-1:0]   denominator,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] NEG_MAX = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2,
    SIGN    = 2'd3
  } state_t;

  state_t state, state_next;

  // Upper N+1 bits hold the signed partial remainder; lower N bits start as
  // the low dividend half and fill with quotient bits as it shifts out.
  logic [2*N:0]   acc;
  logic           qbit;
  logic [CW-1:0]  count;
  logic [N-1:0]   den_mag;
  logic [N-1:0]   num_low;
  logic [N-1:0]   q_mag;
  logic [N-1:0]   r_mag;
  logic           q_neg;
  logic           r_neg;
  logic           signed_op;
  logic           early_zero;
  logic           early_ovf;

  logic           accept;
  logic           num_is_neg;
  logic           den_is_neg;
  logic [2*N-1:0] num_mag_in;
  logic [N-1:0]   den_mag_in;
  logic           early_zero_in;
  logic           early_ovf_in;
  logic [2*N:0]   shifted;
  logic [N:0]     step_hi;
  logic [N-1:0]   rem_fix;
  logic           range_ovf;

  assign accept        = (state == IDLE) && start;
  assign num_is_neg    = signed_mode && numerator[2*N-1];
  assign den_is_neg    = signed_mode && denominator[N-1];
  // The most negative value negates to itself, which read unsigned is the
  // correct magnitude.
  assign num_mag_in    = num_is_neg ? (~numerator + 1'b1) : numerator;
  assign den_mag_in    = den_is_neg ? (~denominator + 1'b1) : denominator;
  assign early_zero_in = (denominator == '0);
  assign early_ovf_in  = (num_mag_in[2*N-1:N] >= den_mag_in);

  // The add/subtract decision uses the sign before the shift; the shift may
  // wrap the N+1 bit window but the step result always lands in range.
  assign shifted = {acc[2*N-1:0], qbit};
  assign step_hi = acc[2*N] ? (shifted[2*N:N] + {1'b0, den_mag})
                            : (shifted[2*N:N] - {1'b0, den_mag});

  // Corrected remainder is in [0, divisor), so N bits of the sum suffice.
  assign rem_fix = acc[2*N] ? (acc[2*N-1:N] + den_mag) : acc[2*N-1:N];

  assign range_ovf = signed_op && (q_neg ? (q_mag > NEG_MAX) : (q_mag > POS_MAX));

  assign busy = (state != IDLE);
  assign done = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        state_next = IDLE;
        if (start) state_next = (early_zero_in || early_ovf_in) ? SIGN : ITER;
      end
      ITER:    state_next = (count == '0) ? CORRECT : ITER;
      CORRECT: state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      qbit       <= 1'b0;
      count      <= '0;
      den_mag    <= '0;
      num_low    <= '0;
      q_mag      <= '0;
      r_mag      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      signed_op  <= 1'b0;
      early_zero <= 1'b0;
      early_ovf  <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      div_zero   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc        <= {1'b0, num_mag_in};
            qbit       <= 1'b0;
            count      <= CW'(N - 1);
            den_mag    <= den_mag_in;
            num_low    <= numerator[N-1:0];
            q_neg      <= num_is_neg ^ den_is_neg;
            r_neg      <= num_is_neg;
            signed_op  <= signed_mode;
            early_zero <= early_zero_in;
            early_ovf  <= early_ovf_in;
            div_zero   <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        ITER: begin
          acc   <= {step_hi, shifted[N-1:0]};
          qbit  <= ~step_hi[N];
          count <= count - 1'b1;
        end
        CORRECT: begin
          // Bit N-1 of the low half is the unused zero shifted in on the
          // first step; it drops out here.
          q_mag <= {acc[N-2:0], qbit};
          r_mag <= rem_fix;
        end
        SIGN: begin
          if (early_zero) begin
            quotient  <= '1;
            remainder <= num_low;
            div_zero  <= 1'b1;
          end else if (early_ovf || range_ovf) begin
            quotient  <= '1;
            remainder <= '0;
            overflow  <= 1'b1;
          end else begin
            quotient  <= q_neg ? (~q_mag + 1'b1) : q_mag;
            remainder <= r_neg ? (~r_mag + 1'b1) : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
